operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Operand-fetch stage directly downstream of the 32x32 register file (2 registered read ports, 1 write port).
//  - Accepts decoded register fields and drives the read addresses.
//  - Captures the read data, which arrives 1 cycle later, and presents operands to execute.
//  - Uses a valid/ready handshake.
//  - Owns the pending-write scoreboard (RAW/WAW stall) and the writeback->operand bypass.
// PARAMETERS
//  XLEN    32  datapath width (rf word width)
//  NREG    32  number of architectural registers
//  AW      5   register address width, = $clog2(NREG)
// PORTS
//  clk        in   1     rising-edge clock
//  rst_n      in   1     async active-low reset
//  in_valid   in   1     decoded instruction present
//  in_ready   out  1     stage accepts this cycle
//  in_ra1     in   AW    source 1 address
//  in_ra2     in   AW    source 2 address
//  in_wa      in   AW    destination address
//  in_we      in   1     instruction writes in_wa
//  rf_ra1     out  AW    to rf ra1; = in_ra1 (combinational)
//  rf_ra2     out  AW    to rf ra2; = in_ra2 (combinational)
//  rf_rd1     in   XLEN  rf rd1; valid the cycle after the address edge
//  rf_rd2     in   XLEN  rf rd2; same timing as rf_rd1
//  wb_we      in   1     writeback strobe; also drives rf we3 externally
//  wb_wa      in   AW    writeback address
//  wb_wd      in   XLEN  writeback data
//  out_valid  out  1     operands valid
//  out_ready  in   1     execute accepts
//  out_rd1    out  XLEN  operand 1
//  out_rd2    out  XLEN  operand 2
//  out_wa     out  AW    destination address, forwarded
//  out_we     out  1     destination write enable, forwarded
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - out_valid=0; out_rd1/2=0; out_wa=0; out_we=0.
//   - Scoreboard busy[NREG-1:0]=0; hold registers=0; in_ready=0 while rst_n=0.
//  Handshake:
//   - Accept when in_valid && in_ready.
//   - in_ready = (!out_valid || out_ready) && !hazard.
//   - Output holds stable while out_valid && !out_ready.
//  Latency: accept at edge E -> out_valid=1 in the cycle after E. Throughput is 1 per cycle when there are no hazards.
//  Hazard:
//   - hz(a) = busy[a] && !clr(a), where clr(a) = wb_we && wb_wa==a (bypass on).
//   - hazard = hz(in_ra1) | hz(in_ra2) | (in_we && hz(in_wa)).
//   - The in_wa term is a WAW stall.
//  Scoreboard:
//   - Each edge: busy[wb_wa] cleared if wb_we.
//   - Then busy[in_wa] set on accept with in_we && in_wa!=0. Set wins on the same index.
//   - busy[0] is always 0.
//   - A wb_we to a non-busy reg is legal; it is ignored by the scoreboard.
//  Bypass capture:
//   - The rf read registers sample pre-write contents, so a wb at the accept edge is seen stale.
//   - At accept edge E, per source: if wb_we && wb_wa==ra && ra!=0, latch byp_hit=1 and byp_d=wb_wd.
//  Operand select, in the first output cycle:
//   - ra==0 -> 0.
//   - Else byp_hit -> byp_d.
//   - Else rf_rd.
//  Output stall: if out_valid && !out_ready at an edge, latch the selected operands into hold regs. Later cycles drive the hold regs, because rf_rd changes every edge.
//  Output transitions:
//   - out_valid 0->1 on accept.
//   - 1->0 on out_ready with no new accept.
//   - Stays 1 on a simultaneous consume+accept; the new operands appear the next cycle.
//  Reset mid-operation: in-flight op dropped, scoreboard cleared. Writebacks of dropped ops are the system's responsibility.
// CONFIGURATION
//  OPFETCH_BYPASS_EN defined (default build):
//   - Same-edge writeback is forwarded.
//   - clr() term in hz() is active.
//  OPFETCH_BYPASS_EN undefined:
//   - No bypass logic or regs; hz(a) = busy[a].
//   - A consumer of a reg written at edge E accepts at E+1 at the earliest, adding 1 stall cycle per RAW.
// STRUCTURE
//  Package regfile_pkg:
//   - XLEN, NREG, AW localparams.
//   - typedef logic [AW-1:0] reg_addr_t; typedef logic [XLEN-1:0] word_t.
//   - typedef struct {reg_addr_t ra1, ra2, wa; logic we;} opf_req_t.
//  Sub-module opfetch_scoreboard: busy vector, set/clear priority, hz() lookup for 3 addresses.
// TESTING
//  - Reset: assert rst_n=0 mid-stream with busy[3]=1 -> out_valid=0, busy all 0, in_ready=1 one cycle after release.
//  - Back-to-back independent: ra1=1, ra2=2 with rf r1=0x11, r2=0x22 and out_ready=1 -> each op appears 1 cycle after accept, no bubbles.
//  - RAW with bypass: op A (we, wa=5), then op B (ra1=5) with wb 5<-0xDEAD on B's accept edge -> out_rd1=0xDEAD. Without the macro, B accepts 1 cycle later and reads 0xDEAD from rf.
//  - WAW stall: A writes r7, B writes r7 -> in_ready=0 until wb r7; B accepts then, and busy[7]=1 afterwards.
//  - Output backpressure: out_ready=0 for 4 cycles while rf_rd toggles -> out_rd1/2 stable, in_ready=0; releases on out_ready=1.
//  - r0: ra1=0, in_we=1, wa=0 with rf_rd1=0xFFFF_FFFF -> out_rd1=0, busy[0] never set, no stall.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Package     : regfile_pkg
// Description : Shared widths and types for the register file and the
//               operand-fetch stage that sits directly downstream of it.
// Contents    : XLEN / NREG / AW, reg_addr_t, word_t, opf_req_t
// Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] word_t;

    // Decoded register fields of one instruction
    typedef struct packed {
        reg_addr_t ra1;
        reg_addr_t ra2;
        reg_addr_t wa;
        logic      we;
    } opf_req_t;

endpackage
`default_nettype wire

// File: rtl/operand_fetch_if.sv
`default_nettype none
// ============================================================================
// Interface   : operand_fetch_if
// Description : Bundles the decode-side request, the register-file read and
//               writeback buses and the execute-side operand handshake.
// Modports    : slave  - the operand-fetch stage
//               master - the surrounding pipeline / register file
// Revision    : 1.0  initial release
// ============================================================================
interface operand_fetch_if;
    import regfile_pkg::*;

    // decode -> fetch
    logic      in_valid;
    logic      in_ready;
    reg_addr_t in_ra1;
    reg_addr_t in_ra2;
    reg_addr_t in_wa;
    logic      in_we;
    // fetch <-> register file
    reg_addr_t rf_ra1;
    reg_addr_t rf_ra2;
    word_t     rf_rd1;
    word_t     rf_rd2;
    // writeback (also feeds the register file write port)
    logic      wb_we;
    reg_addr_t wb_wa;
    word_t     wb_wd;
    // fetch -> execute
    logic      out_valid;
    logic      out_ready;
    word_t     out_rd1;
    word_t     out_rd2;
    reg_addr_t out_wa;
    logic      out_we;

    modport slave (
        input  in_valid, in_ra1, in_ra2, in_wa, in_we,
        input  rf_rd1, rf_rd2,
        input  wb_we, wb_wa, wb_wd,
        input  out_ready,
        output in_ready, rf_ra1, rf_ra2,
        output out_valid, out_rd1, out_rd2, out_wa, out_we
    );

    modport master (
        output in_valid, in_ra1, in_ra2, in_wa, in_we,
        output rf_rd1, rf_rd2,
        output wb_we, wb_wa, wb_wd,
        output out_ready,
        input  in_ready, rf_ra1, rf_ra2,
        input  out_valid, out_rd1, out_rd2, out_wa, out_we
    );

endinterface
`default_nettype wire

// File: rtl/opfetch_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : opfetch_scoreboard
// Description : Pending-write scoreboard. One busy bit per architectural
//               register; writeback clears, an accepted writer sets (set wins
//               on the same index). r0 is never busy. Three hazard lookups.
// Ports       : clk, rst_n            clock, async active-low reset
//               wb_we_i, wb_wa_i      writeback clear
//               set_en_i, set_wa_i    accepted-writer set
//               lk{1,2,3}_i           lookup addresses
//               hz{1,2,3}_o           hazard for each lookup
// Config      : OPFETCH_BYPASS_EN - a same-cycle writeback masks the hazard
// Revision    : 1.0  initial release
// ============================================================================
module opfetch_scoreboard
    import regfile_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst_n,
    input  wire logic      wb_we_i,
    input  wire reg_addr_t wb_wa_i,
    input  wire logic      set_en_i,
    input  wire reg_addr_t set_wa_i,
    input  wire reg_addr_t lk1_i,
    input  wire reg_addr_t lk2_i,
    input  wire reg_addr_t lk3_i,
    output logic           hz1_o,
    output logic           hz2_o,
    output logic           hz3_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (wb_we_i) begin
            busy_d[wb_wa_i] = 1'b0;
        end
        if (set_en_i && (set_wa_i != '0)) begin
            busy_d[set_wa_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    function automatic logic hz(input reg_addr_t a);
`ifdef OPFETCH_BYPASS_EN
        // A writeback landing this edge is forwarded, so it does not block
        return busy_q[a] && !(wb_we_i && (wb_wa_i == a));
`else
        return busy_q[a];
`endif
    endfunction

    assign hz1_o = hz(lk1_i);
    assign hz2_o = hz(lk2_i);
    assign hz3_o = hz(lk3_i);

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Operand-fetch stage behind a 2R/1W register file with
//               registered reads. Drives read addresses combinationally,
//               captures read data one cycle later, stalls on RAW/WAW via the
//               scoreboard and presents operands with a valid/ready handshake.
// Ports       : clk     rising-edge clock
//               rst_n   async active-low reset
//               bus     operand_fetch_if.slave (decode, rf, wb, execute)
// Config      : OPFETCH_BYPASS_EN - forward a writeback coinciding with the
//               accept edge into the captured operand and drop the hazard
// Revision    : 1.0  initial release
// ============================================================================
module operand_fetch
    import regfile_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    operand_fetch_if.slave  bus
);

    opf_req_t  w_req;
    logic      w_hz1, w_hz2, w_hzw;
    logic      w_hazard;
    logic      w_accept;
    word_t     w_sel1, w_sel2;

    logic      out_valid_q;
    reg_addr_t src1_q, src2_q;
    reg_addr_t dst_wa_q;
    logic      dst_we_q;
    logic      use_hold_q;
    word_t     hold1_q, hold2_q;

    assign w_req = '{ra1: bus.in_ra1, ra2: bus.in_ra2, wa: bus.in_wa, we: bus.in_we};

    assign bus.rf_ra1 = w_req.ra1;
    assign bus.rf_ra2 = w_req.ra2;

    opfetch_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_we_i  (bus.wb_we),
        .wb_wa_i  (bus.wb_wa),
        .set_en_i (w_accept & w_req.we),
        .set_wa_i (w_req.wa),
        .lk1_i    (w_req.ra1),
        .lk2_i    (w_req.ra2),
        .lk3_i    (w_req.wa),
        .hz1_o    (w_hz1),
        .hz2_o    (w_hz2),
        .hz3_o    (w_hzw)
    );

    assign w_hazard     = w_hz1 | w_hz2 | (w_req.we & w_hzw);
    assign bus.in_ready = rst_n & (~out_valid_q | bus.out_ready) & ~w_hazard;
    assign w_accept     = bus.in_valid & bus.in_ready;

`ifdef OPFETCH_BYPASS_EN
    // The rf read registers sample pre-write contents, so a writeback on the
    // accept edge must be captured here instead.
    logic  byp_hit1_q, byp_hit2_q;
    word_t byp1_q, byp2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_hit1_q <= 1'b0;
            byp_hit2_q <= 1'b0;
            byp1_q     <= '0;
            byp2_q     <= '0;
        end else if (w_accept) begin
            byp_hit1_q <= bus.wb_we && (bus.wb_wa == w_req.ra1) && (w_req.ra1 != '0);
            byp_hit2_q <= bus.wb_we && (bus.wb_wa == w_req.ra2) && (w_req.ra2 != '0);
            byp1_q     <= bus.wb_wd;
            byp2_q     <= bus.wb_wd;
        end
    end
`else
    logic w_unused_wd;
    assign w_unused_wd = ^bus.wb_wd;
`endif

    // First output cycle uses live rf data; once stalled, the hold copy wins
    // because rf_rd follows the read address every edge.
    always_comb begin
        w_sel1 = bus.rf_rd1;
        w_sel2 = bus.rf_rd2;
`ifdef OPFETCH_BYPASS_EN
        if (byp_hit1_q) w_sel1 = byp1_q;
        if (byp_hit2_q) w_sel2 = byp2_q;
`endif
        if (src1_q == '0) w_sel1 = '0;
        if (src2_q == '0) w_sel2 = '0;
        if (use_hold_q) begin
            w_sel1 = hold1_q;
            w_sel2 = hold2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            dst_wa_q    <= '0;
            dst_we_q    <= 1'b0;
            use_hold_q  <= 1'b0;
            hold1_q     <= '0;
            hold2_q     <= '0;
        end else begin
            if (w_accept) begin
                out_valid_q <= 1'b1;
                src1_q      <= w_req.ra1;
                src2_q      <= w_req.ra2;
                dst_wa_q    <= w_req.wa;
                dst_we_q    <= w_req.we;
                use_hold_q  <= 1'b0;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            // Accept and stall are mutually exclusive (in_ready needs out_ready)
            if (out_valid_q && !bus.out_ready) begin
                hold1_q    <= w_sel1;
                hold2_q    <= w_sel2;
                use_hold_q <= 1'b1;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_rd1   = w_sel1;
    assign bus.out_rd2   = w_sel2;
    assign bus.out_wa    = dst_wa_q;
    assign bus.out_we    = dst_we_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch
// Description : Self-checking bench for operand_fetch. Directed scenarios
//               followed by random traffic, compared against an
//               architectural model (register values, pending writers,
//               expected-operand queue, writeback schedule).
// Config      : OPFETCH_BYPASS_EN - selects the bypass rules in the model
// Revision    : 1.0  initial release
// ============================================================================
module tb_operand_fetch;
    import regfile_pkg::*;

`ifdef OPFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    operand_fetch_if bus();

    operand_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic word_t init_val(input int i);
        if (i == 0) return 32'hFFFF_FFFF;
        if (i == 1) return 32'h0000_0011;
        if (i == 2) return 32'h0000_0022;
        return 32'h1000_0000 + word_t'(i) * 32'h0101;
    endfunction

    // Environment register file: registered reads see pre-write contents
    word_t rf_mem [NREG];
    bit    rf_loaded;
    always @(posedge clk) begin
        if (!rf_loaded) begin
            for (int i = 0; i < NREG; i++) rf_mem[i] <= init_val(i);
            rf_loaded <= 1'b1;
        end else begin
            bus.rf_rd1 <= rf_mem[bus.rf_ra1];
            bus.rf_rd2 <= rf_mem[bus.rf_ra2];
            if (bus.wb_we) rf_mem[bus.wb_wa] <= bus.wb_wd;
        end
    end

    // ---------------- reference model state ----------------
    typedef struct {
        word_t     rd1;
        word_t     rd2;
        reg_addr_t wa;
        logic      we;
    } exp_t;
    typedef struct {
        int        due;
        reg_addr_t wa;
    } wb_t;

    word_t arch [NREG];
    bit    pending [NREG];
    bit    exp_valid;
    exp_t  expq[$];
    wb_t   wbq[$];
    int    cyc;
    int    n_checks, n_errors;
    bit    out_rdy;
    bit    last_acc;
    bit    rnd_wb, no_wb, fix_wd_en;
    word_t fix_wd;
    int    dly_min, dly_max;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit mhz(input reg_addr_t a, input bit wbv, input reg_addr_t wba);
        return pending[a] && !(BYP && wbv && (wba == a));
    endfunction

    function automatic word_t opval(input reg_addr_t ra, input bit wbv,
                                    input reg_addr_t wba, input word_t wbd);
        if (ra == '0) return '0;
        if (BYP && wbv && (wba == ra)) return wbd;
        return arch[ra];
    endfunction

    // One clock cycle: entered and left at posedge+1
    task automatic step(input bit v, input reg_addr_t ra1, input reg_addr_t ra2,
                        input reg_addr_t wa, input bit we);
        bit        wbv, rdy, acc, cons;
        reg_addr_t wba;
        word_t     wbd;
        exp_t      e;
        wbv = 1'b0; wba = '0; wbd = '0;
        if (rst_n && wbq.size() > 0 && wbq[0].due <= cyc) begin
            wbv = 1'b1;
            wba = wbq[0].wa;
            wbd = fix_wd_en ? fix_wd : word_t'($urandom);
            wbq.delete(0);
        end else if (rst_n && rnd_wb && $urandom_range(7) == 0) begin
            wba = reg_addr_t'($urandom_range(NREG - 1));
            if (!pending[wba]) begin
                wbv = 1'b1;
                wbd = word_t'($urandom);
            end
        end
        bus.in_valid  = v;
        bus.in_ra1    = ra1;
        bus.in_ra2    = ra2;
        bus.in_wa     = wa;
        bus.in_we     = we;
        bus.wb_we     = wbv;
        bus.wb_wa     = wba;
        bus.wb_wd     = wbd;
        bus.out_ready = out_rdy;

        rdy  = rst_n && (!exp_valid || out_rdy) &&
               !(mhz(ra1, wbv, wba) || mhz(ra2, wbv, wba) || (we && mhz(wa, wbv, wba)));
        acc  = v && rdy;
        cons = rst_n && exp_valid && out_rdy;

        @(negedge clk);
        check_eq("in_ready", 32'(bus.in_ready), 32'(rdy));
        check_eq("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        if (exp_valid && expq.size() > 0) begin
            check_eq("out_rd1", bus.out_rd1, expq[0].rd1);
            check_eq("out_rd2", bus.out_rd2, expq[0].rd2);
            check_eq("out_wa", 32'(bus.out_wa), 32'(expq[0].wa));
            check_eq("out_we", 32'(bus.out_we), 32'(expq[0].we));
        end
        if (!rst_n) begin
            check_eq("rst_out_rd1", bus.out_rd1, 32'h0);
            check_eq("rst_out_rd2", bus.out_rd2, 32'h0);
            check_eq("rst_out_wa", 32'(bus.out_wa), 32'h0);
            check_eq("rst_out_we", 32'(bus.out_we), 32'h0);
        end
        if (acc) begin
            e.rd1 = opval(ra1, wbv, wba, wbd);
            e.rd2 = opval(ra2, wbv, wba, wbd);
            e.wa  = wa;
            e.we  = we;
        end

        @(posedge clk);
        #1;
        if (cons && expq.size() > 0) begin
            if (!no_wb && expq[0].we && expq[0].wa != '0)
                wbq.push_back('{cyc + int'($urandom_range(dly_max, dly_min)), expq[0].wa});
            expq.delete(0);
        end
        if (wbv) begin
            pending[wba] = 1'b0;
            arch[wba]    = wbd;
        end
        if (acc) begin
            if (we && wa != '0) pending[wa] = 1'b1;
            expq.push_back(e);
        end
        exp_valid = acc ? 1'b1 : (cons ? 1'b0 : exp_valid);
        last_acc  = acc;
        cyc++;
    endtask

    task automatic issue(input reg_addr_t ra1, input reg_addr_t ra2, input reg_addr_t wa,
                         input bit we, output int stalls);
        stalls = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b1, ra1, ra2, wa, we);
            if (last_acc) break;
            stalls++;
        end
        check_eq("issue_accepted", 32'(last_acc), 32'h1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic model_reset();
        exp_valid = 1'b0;
        expq.delete();
        wbq.delete();
        for (int i = 0; i < NREG; i++) pending[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int    st;
        word_t first1, first2;
        for (int i = 0; i < NREG; i++) begin
            arch[i]    = init_val(i);
            pending[i] = 1'b0;
        end
        n_checks = 0; n_errors = 0; cyc = 0;
        out_rdy = 1'b1; rnd_wb = 1'b0; no_wb = 1'b0; fix_wd_en = 1'b0; fix_wd = '0;
        dly_min = 1; dly_max = 4;
        exp_valid = 1'b0;
        bus.in_valid = 1'b0; bus.in_ra1 = '0; bus.in_ra2 = '0; bus.in_wa = '0; bus.in_we = 1'b0;
        bus.wb_we = 1'b0; bus.wb_wa = '0; bus.wb_wd = '0; bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 5'd1, 5'd2, 5'd3, 1'b1);   // held in reset
        step(1'b0, '0, '0, '0, 1'b0);
        rst_n = 1'b1;
        idle(1);

        // Back-to-back independent ops, no bubbles
        for (int k = 0; k < 3; k++) begin
            issue(5'd1, 5'd2, 5'd0, 1'b0, st);
            check_eq("b2b_stalls", 32'(st), 32'h0);
            check_eq("b2b_rd1", bus.out_rd1, 32'h11);
            check_eq("b2b_rd2", bus.out_rd2, 32'h22);
        end
        idle(2);

        // RAW: consumer of r5 meets the writeback of r5
        dly_min = 1; dly_max = 1; fix_wd_en = 1'b1; fix_wd = 32'h0000_DEAD;
        issue(5'd0, 5'd0, 5'd5, 1'b1, st);
        issue(5'd5, 5'd0, 5'd0, 1'b0, st);
        check_eq("raw_stalls", 32'(st), BYP ? 32'd1 : 32'd2);
        check_eq("raw_rd1", bus.out_rd1, 32'h0000_DEAD);
        fix_wd_en = 1'b0;
        idle(3);

        // WAW: second writer of r7 waits for the first writeback
        dly_min = 3; dly_max = 3;
        issue(5'd0, 5'd0, 5'd7, 1'b1, st);
        issue(5'd0, 5'd0, 5'd7, 1'b1, st);
        check_eq("waw_stalls", 32'(st), BYP ? 32'd3 : 32'd4);
        issue(5'd7, 5'd0, 5'd0, 1'b0, st);
        check_eq("waw_busy_after", 32'(st > 0), 32'h1);
        idle(6);

        // Output backpressure while the read addresses keep moving
        dly_min = 1; dly_max = 4;
        out_rdy = 1'b0;
        issue(5'd1, 5'd2, 5'd0, 1'b0, st);
        first1 = bus.out_rd1;
        first2 = bus.out_rd2;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, reg_addr_t'(k + 3), reg_addr_t'(k + 8), 5'd0, 1'b0);
            check_eq("bp_hold_rd1", bus.out_rd1, first1);
            check_eq("bp_hold_rd2", bus.out_rd2, first2);
        end
        out_rdy = 1'b1;
        idle(2);

        // r0: never busy, always reads zero
        for (int k = 0; k < 2; k++) begin
            issue(5'd0, 5'd0, 5'd0, 1'b1, st);
            check_eq("r0_stalls", 32'(st), 32'h0);
            check_eq("r0_rd1", bus.out_rd1, 32'h0);
        end
        idle(2);

        // Reset mid-stream with r3 pending
        no_wb = 1'b1;
        issue(5'd0, 5'd0, 5'd3, 1'b1, st);
        step(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        step(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
        rst_n = 1'b1;
        no_wb = 1'b0;
        issue(5'd3, 5'd0, 5'd0, 1'b0, st);
        check_eq("rst_no_stall", 32'(st), 32'h0);
        idle(2);

        // Random traffic over a small register window to provoke hazards
        rnd_wb = 1'b1;
        for (int k = 0; k < 600; k++) begin
            out_rdy = ($urandom_range(3) != 0);
            step(1'(($urandom_range(3) != 0)),
                 reg_addr_t'($urandom_range(7)), reg_addr_t'($urandom_range(7)),
                 reg_addr_t'($urandom_range(7)), 1'($urandom_range(1)));
        end
        out_rdy = 1'b1;
        rnd_wb = 1'b0;
        idle(12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
